if_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipeline: owns the program counter, drives the instruction-memory request/acknowledge handshake, and holds the IF/ID pipeline register that feeds `pc_i`/`inst_i` into the decode stage. It applies decode-stage stalls, memory-stage structural stalls (shared SRAM), and branch redirects (one delay slot) coming back from decode, and inserts NOP bubbles when no instruction is available.

---
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory handshake and the
// IF/ID pipeline register, with decode/memory stalls and delayed-branch redirects.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_id,
  input  logic        stall_req_mem,
  input  logic        branch_flag_i,
  input  logic [15:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] pc_o,
  output logic [15:0] inst_o
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] pc;
  logic [15:0] pc_n;
  logic [15:0] buf_inst;
  logic [15:0] buf_inst_n;
  logic        redir_pend;
  logic        redir_pend_n;
  logic [15:0] redir_addr;
  logic [15:0] redir_addr_n;
  logic [15:0] inst_n;
  logic [15:0] pc_out_n;

  logic        fetch_done;
  logic        branch_cap;
  logic [15:0] pc_inc;
  logic [15:0] pc_adv;

  assign imem_req_o  = (state == FETCH) && !stall_req_mem && !rst;
  assign imem_addr_o = pc;
  assign fetch_done  = imem_req_o && imem_ack_i;
  assign branch_cap  = branch_flag_i && !stall_req_id;
  assign pc_inc      = pc + 16'd1;

  // An already-recorded redirect is older than one arriving this cycle, so it wins.
  always_comb begin
    pc_adv = pc_inc;
    if (redir_pend) begin
      pc_adv = redir_addr;
    end else if (branch_cap) begin
      pc_adv = branch_addr_i;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    buf_inst_n   = buf_inst;
    redir_pend_n = redir_pend;
    redir_addr_n = redir_addr;
    inst_n       = inst_o;
    pc_out_n     = pc_o;

    if (branch_cap) begin
      redir_pend_n = 1'b1;
      redir_addr_n = branch_addr_i;
    end

    unique case (state)
      FETCH: begin
        if (fetch_done && stall_req_id) begin
          buf_inst_n = imem_rdata_i;
          state_n    = HOLD;
        end else if (fetch_done) begin
          inst_n       = imem_rdata_i;
          pc_out_n     = pc_inc;
          pc_n         = pc_adv;
          redir_pend_n = 1'b0;
        end else if (!stall_req_id) begin
          inst_n = NOP_INST;
        end
      end
      HOLD: begin
        if (!stall_req_id) begin
          inst_n       = buf_inst;
          pc_out_n     = pc_inc;
          pc_n         = pc_adv;
          redir_pend_n = 1'b0;
          state_n      = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      buf_inst   <= NOP_INST;
      redir_pend <= 1'b0;
      redir_addr <= RESET_PC;
      inst_o     <= NOP_INST;
      pc_o       <= RESET_PC;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      buf_inst   <= buf_inst_n;
      redir_pend <= redir_pend_n;
      redir_addr <= redir_addr_n;
      inst_o     <= inst_n;
      pc_o       <= pc_out_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle stimulus tables with the expected
// IF/ID contents queued at drive time and compared after the clock edge.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_req_id;
  logic        stall_req_mem;
  logic        branch_flag_i;
  logic [15:0] branch_addr_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i;
  logic [15:0] pc_o;
  logic [15:0] inst_o;

  int checks   = 0;
  int failures = 0;

  // One cycle of stimulus plus what the stage must show in that cycle and after its edge.
  typedef struct packed {
    logic [3:0]  ctl;
    logic [15:0] baddr;
    logic        ack;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic [15:0] inst;
    logic [15:0] pc;
  } row_t;

  logic [31:0] exp_q[$];

  if_stage #(
    .RESET_PC(16'h0000),
    .NOP_INST(16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req_id (stall_req_id),
    .stall_req_mem(stall_req_mem),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // ctl = {rst, stall_req_id, stall_req_mem, branch_flag_i}
  function automatic row_t r(input logic [3:0] ctl, input logic [15:0] baddr,
                             input logic ack, input logic [15:0] rdata,
                             input logic req, input logic [15:0] addr,
                             input logic [15:0] inst, input logic [15:0] pc);
    row_t x;
    x.ctl = ctl; x.baddr = baddr; x.ack = ack; x.rdata = rdata;
    x.req = req; x.addr = addr; x.inst = inst; x.pc = pc;
    return x;
  endfunction

  task automatic drive(input row_t x);
    rst           = x.ctl[3];
    stall_req_id  = x.ctl[2];
    stall_req_mem = x.ctl[1];
    branch_flag_i = x.ctl[0];
    branch_addr_i = x.baddr;
    imem_ack_i    = x.ack;
    imem_rdata_i  = x.rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0800, 16'h0000));
    rows.push_back(r(4'b1000, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0800, 16'h0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req) begin
        failures++;
        $display("[TB] FAIL reset_req row%0d: got %b want %b", i, imem_req_o, rows[i].req);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL reset_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_straight_line();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4101, 1'b1, 16'h0000, 16'h4101, 16'h0001));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4202, 1'b1, 16'h0001, 16'h4202, 16'h0002));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4303, 1'b1, 16'h0002, 16'h4303, 16'h0003));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL straight_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL straight_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_mem_stall();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0010, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 16'h0003, 16'h0800, 16'h0003));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4404, 1'b1, 16'h0003, 16'h4404, 16'h0004));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL memstall_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL memstall_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_id_stall();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4505, 1'b1, 16'h0004, 16'h4505, 16'h0005));
    rows.push_back(r(4'b0100, 16'h0000, 1'b1, 16'h6A07, 1'b1, 16'h0005, 16'h4505, 16'h0005));
    rows.push_back(r(4'b0100, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h4505, 16'h0005));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0005, 16'h6A07, 16'h0006));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4707, 1'b1, 16'h0006, 16'h4707, 16'h0007));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL idstall_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL idstall_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4808, 1'b1, 16'h0007, 16'h4808, 16'h0008));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'hC020, 1'b1, 16'h0008, 16'hC020, 16'h0009));
    rows.push_back(r(4'b0001, 16'h0020, 1'b1, 16'h4909, 1'b1, 16'h0009, 16'h4909, 16'h000A));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h5020, 1'b1, 16'h0020, 16'h5020, 16'h0021));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL branch_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL branch_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  // A branch raised under a decode stall must be dropped; then a slow delay-slot fetch.
  task automatic test_branch_latency();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0101, 16'h0BAD, 1'b0, 16'h0000, 1'b1, 16'h0021, 16'h5020, 16'h0021));
    rows.push_back(r(4'b0001, 16'h0009, 1'b1, 16'h5121, 1'b1, 16'h0021, 16'h5121, 16'h0022));
    rows.push_back(r(4'b0001, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0009, 16'h0800, 16'h0022));
    rows.push_back(r(4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0009, 16'h0800, 16'h0022));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h4909, 1'b1, 16'h0009, 16'h4909, 16'h000A));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h6040, 1'b1, 16'h0040, 16'h6040, 16'h0041));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL brlat_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL brlat_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0100, 16'h0000, 1'b1, 16'h7777, 1'b1, 16'h0041, 16'h6040, 16'h0041));
    rows.push_back(r(4'b1100, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0041, 16'h0800, 16'h0000));
    rows.push_back(r(4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0800, 16'h0000));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h1000, 1'b1, 16'h0000, 16'h1000, 16'h0001));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL rsthold_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL rsthold_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_pc_wrap();
    row_t rows[$];
    logic [31:0] e;
    rows.push_back(r(4'b0001, 16'hFFFF, 1'b1, 16'h1001, 1'b1, 16'h0001, 16'h1001, 16'h0002));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h2FFF, 1'b1, 16'hFFFF, 16'h2FFF, 16'h0000));
    rows.push_back(r(4'b0000, 16'h0000, 1'b1, 16'h3000, 1'b1, 16'h0000, 16'h3000, 16'h0001));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back({rows[i].inst, rows[i].pc});
      #2;
      checks++;
      if (imem_req_o !== rows[i].req || imem_addr_o !== rows[i].addr) begin
        failures++;
        $display("[TB] FAIL wrap_req row%0d: got req=%b addr=%h want req=%b addr=%h", i, imem_req_o, imem_addr_o, rows[i].req, rows[i].addr);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({inst_o, pc_o} !== e) begin
        failures++;
        $display("[TB] FAIL wrap_ifid row%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst_o, pc_o, e[31:16], e[15:0]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    stall_req_id  = 1'b0;
    stall_req_mem = 1'b0;
    branch_flag_i = 1'b0;
    branch_addr_i = 16'h0000;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 16'h0000;

    test_reset();
    test_straight_line();
    test_mem_stall();
    test_id_stall();
    test_branch();
    test_branch_latency();
    test_reset_in_hold();
    test_pc_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
